// File: rtl/gcd_pkg.sv
// Shared state encoding and sizing helpers for the GCD engine and its datapath.
package gcd_pkg;

   localparam logic [1:0] ENC_IDLE = 2'd0;
   localparam logic [1:0] ENC_TEST = 2'd1;
   localparam logic [1:0] ENC_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ENC_IDLE,
      TEST = ENC_TEST,
      DONE = ENC_DONE
   } state_t;

   // k counts common factors of two; it stays below WIDTH, so this width always holds it.
   function automatic int k_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand and result handshakes of the GCD engine, plus its status outputs.
interface gcd_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x_in;
   logic [WIDTH-1:0] y_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd_out;
   logic [WIDTH-1:0] iter_count;
   logic             zero_flag;
   logic             busy;

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, gcd_out, iter_count, zero_flag, busy
   );

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, gcd_out, iter_count, zero_flag, busy
   );

endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, comparators and subtract/shift update for one GCD reduction step.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit BINARY = 1'b0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   output logic             finish,
   output logic             both_zero,
   output logic [WIDTH-1:0] result
);

   localparam int KW = k_width(WIDTH);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [KW-1:0]    k;
   logic             eq;
   logic             lt;
   logic             x_zero;
   logic             y_zero;
   logic             x_even;
   logic             y_even;

   assign eq        = (x == y);
   assign lt        = (x < y);
   assign x_zero    = (x == '0);
   assign y_zero    = (y == '0);
   assign x_even    = ~x[0];
   assign y_even    = ~y[0];
   assign finish    = x_zero | y_zero | eq;
   assign both_zero = x_zero & y_zero;
   // With one operand zero the other is the odd part; with equal operands x|y == x.
   assign result    = (x | y) << k;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         x <= '0;
         y <= '0;
         k <= '0;
      end else if (load) begin
         x <= x_in;
         y <= y_in;
         k <= '0;
      end else if (step) begin
         if (BINARY && x_even && y_even) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + KW'(1);
         end else if (BINARY && x_even) begin
            x <= x >> 1;
         end else if (BINARY && y_even) begin
            y <= y >> 1;
         end else if (lt) begin
            y <= y - x;
         end else begin
            x <= x - y;
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: control FSM, iteration counter, result registers and handshakes.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit BINARY = 1'b0
) (
   input logic  clk,
   input logic  clr,
   gcd_if.slave bus
);

   state_t           state;
   state_t           state_next;
   logic             load;
   logic             step;
   logic             capture;
   logic             finish;
   logic             both_zero;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] gcd_q;
   logic [WIDTH-1:0] iter_q;
   logic             zero_q;

   gcd_datapath #(
      .WIDTH  (WIDTH),
      .BINARY (BINARY)
   ) u_datapath (
      .clk       (clk),
      .clr       (clr),
      .load      (load),
      .step      (step),
      .x_in      (bus.x_in),
      .y_in      (bus.y_in),
      .finish    (finish),
      .both_zero (both_zero),
      .result    (result)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               load       = 1'b1;
               state_next = TEST;
            end
         end
         TEST: begin
            if (finish) begin
               capture    = 1'b1;
               state_next = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         gcd_q  <= '0;
         iter_q <= '0;
         zero_q <= 1'b0;
      end else if (load) begin
         iter_q <= '0;
      end else if (step) begin
         if (iter_q != '1) iter_q <= iter_q + WIDTH'(1);
      end else if (capture) begin
         gcd_q  <= result;
         zero_q <= both_zero;
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.busy       = (state == TEST);
   assign bus.gcd_out    = gcd_q;
   assign bus.iter_count = iter_q;
   assign bus.zero_flag  = zero_q;

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised, self-contained GCD unit: operand registers, subtract/shift datapath and control FSM in one block, with valid/ready handshakes on both input and output. It succeeds the fixed-width control-only GCD FSM. It adds:
- a generic operand width,
- a selectable algorithm (subtractive Euclid or Stein binary),
- zero-operand handling,
- an iteration counter.

It sits between an operand source and a result consumer, and handles one transaction at a time.

## Interface
- WIDTH, 16, operand/result width in bits (≥2)
- BINARY, 0, 0 = subtractive Euclid, 1 = Stein binary GCD
- clk  in  1  clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands x_in/y_in are valid
- in_ready  out  1  engine can accept operands
- x_in  in  WIDTH  operand X, unsigned
- y_in  in  WIDTH  operand Y, unsigned
- out_valid  out  1  result is valid
- out_ready  in  1  consumer accepts the result
- gcd_out  out  WIDTH  result, held stable while out_valid=1
- iter_count  out  WIDTH  number of update cycles for the current/last transaction; saturates at all-ones
- zero_flag  out  1  both operands were 0 (gcd_out=0)
- busy  out  1  state is TEST

## Operation
- States: IDLE, TEST, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: load x_in→X and y_in→Y, clear k and iter_count, then go to TEST.
- **TEST**, one decision per cycle, evaluated in priority order:
  1. X==0 or Y==0: result=(X|Y)<<k; zero_flag=(X==0&&Y==0); go to DONE.
  2. X==Y: result=X<<k; go to DONE.
  3. BINARY=0: the larger register takes larger−smaller; iter_count++.
  4. BINARY=1, checked in this order:
     - both even: X>>=1, Y>>=1, k++
     - X even: X>>=1
     - Y even: Y>>=1
     - else the larger register takes larger−smaller

     Each of these is one iter_count++.
- **DONE**
  - out_valid=1.
  - gcd_out, zero_flag and iter_count are held.
  - On out_valid&&out_ready: go to IDLE; out_valid drops on the next edge. zero_flag, gcd_out and iter_count keep their values until the next acceptance.
- No overlap: in_ready=0 in TEST and DONE. in_valid is ignored outside IDLE.
- **Arithmetic**
  - All unsigned, WIDTH bits.
  - Subtraction never underflows, because the larger operand is selected first.
  - k is $clog2(WIDTH)+1 bits and never exceeds WIDTH−1.
  - The result shift cannot overflow, because the true GCD fits in WIDTH.
- iter_count saturates at 2^WIDTH−1. The subtractive worst case, gcd(2^WIDTH−1, 1), needs 2^WIDTH−2 updates, so it does not saturate.
- **Reset**: clr asserted at any time, including mid-TEST or in DONE, immediately forces IDLE and clears X, Y, k, gcd_out, iter_count and zero_flag. An in-flight transaction is lost and no result is produced.

## Timing
- Reset values:
  - in_ready=1 (IDLE)
  - out_valid=0
  - gcd_out=0
  - iter_count=0
  - zero_flag=0
  - busy=0
- Acceptance edge E0 is followed by TEST cycles, numbering iter_count+1.
- out_valid rises at edge E0+iter_count+1.
- Minimum latency is 1 cycle (zero operand or equal operands).
- Back-to-back throughput: with out_ready held high, DONE lasts 1 cycle and IDLE lasts 1 cycle before the next acceptance.
- out_ready=0 holds DONE indefinitely with the outputs stable.
- clr deassertion takes effect on the next rising edge. in_valid may be accepted at the first edge after release.

## Structure
- **gcd_pkg**
  - state encoding localparams: IDLE=2'd0, TEST=2'd1, DONE=2'd2
  - a function computing the k width from WIDTH
- **Sub-module gcd_datapath**, parametrised by WIDTH and BINARY. It contains:
  - the X, Y and k registers
  - the comparators (eq, lt, X/Y zero, X/Y even)
  - the subtract/shift next-value muxes, driven by load/step enables from the FSM
- **gcd_engine** contains:
  - the FSM
  - the iter_count counter
  - the result and zero_flag registers
  - the handshake logic

## Test plan
- WIDTH=16, BINARY=0, x=12, y=18, out_ready=1 → gcd_out=6, iter_count=2, out_valid 3 cycles after acceptance, zero_flag=0.
- WIDTH=16, BINARY=1, x=12, y=18 → gcd_out=6, iter_count=4, out_valid 5 cycles after acceptance.
- Zero operands, each mode:
  - x=0, y=0 → gcd_out=0, zero_flag=1, iter_count=0, latency 1.
  - x=0, y=7 → gcd_out=7, zero_flag=0.
- Output backpressure, BINARY=0, x=255, y=1, out_ready=0 for 10 cycles after out_valid:
  - gcd_out=1 and iter_count=254 held.
  - in_ready stays 0 and in_valid pulses are ignored.
  - Raising out_ready returns to IDLE, with in_ready=1 one edge later.
- Reset mid-operation: assert clr asynchronously (between edges) during TEST of x=1000, y=3 → all outputs immediately at reset values. After release, accept x=21, y=14 → gcd_out=7.
- Random regression, WIDTH=8, both modes, 1000 operand pairs with random in_valid/out_ready stalls → gcd_out matches the reference model, and no transaction is dropped or duplicated.
